// File: rtl/pc_gen_if.sv
// Bundle between the fetch-stage control (hazard unit, decode, CP0) and the
// program-counter generator. The control side drives the redirect request
// and the RAS call; the generator drives back the PC and the RAS status.
interface pc_gen_if #(
  parameter int XLEN = 32
) ();

  // Redirect and hazard controls, sampled on the rising clock edge.
  logic            req;
  logic            stall;
  logic [2:0]      pc_op;
  logic [XLEN-1:0] br_off;
  logic [XLEN-1:0] j_target;
  logic [XLEN-1:0] jr_target;
  logic [XLEN-1:0] epc;
  logic            call;

  // Registered PC and return-address-stack status.
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] ras_top;
  logic            ras_empty;
  logic            ras_full;
  logic            ras_underflow;
  logic            pc_misaligned;

  // Control side: decides where fetch goes next.
  modport master (
    output req, stall, pc_op, br_off, j_target, jr_target, epc, call,
    input  pc, ras_top, ras_empty, ras_full, ras_underflow, pc_misaligned
  );

  // Generator side: owns the PC register and the RAS.
  modport slave (
    input  req, stall, pc_op, br_off, j_target, jr_target, epc, call,
    output pc, ras_top, ras_empty, ras_full, ras_underflow, pc_misaligned
  );

endinterface : pc_gen_if

// File: rtl/pc_gen.sv
// Program-counter generator at the head of the fetch stage.
// Holds the current PC and picks the next one with priority
// reset > exception request > stall > per-cycle redirect op.
// A circular return-address stack is pushed on calls and popped on RET;
// a push into a full stack silently overwrites the oldest entry.
module pc_gen #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_VEC   = XLEN'(32'h0000_3000),
  parameter logic [XLEN-1:0] EXC_VEC     = XLEN'(32'h0000_4180),
  parameter int              RAS_DEPTH   = 4,
  parameter int              LINK_OFFSET = 8
) (
  input logic    clk,
  input logic    reset,
  pc_gen_if.slave bus
);

  // Pointer wraps naturally because the depth is a power of two; the
  // count needs one more bit so that "full" is distinguishable from "empty".
  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

  // Redirect encodings; codes 6 and 7 are reserved and hold the PC.
  typedef enum logic [2:0] {
    OP_NORMAL = 3'd0,
    OP_BRANCH = 3'd1,
    OP_JUMP   = 3'd2,
    OP_JR     = 3'd3,
    OP_ERET   = 3'd4,
    OP_RET    = 3'd5
  } pc_op_e;

  // Architectural state.
  logic [XLEN-1:0]  pc_q;
  logic [XLEN-1:0]  ras_q [RAS_DEPTH];
  logic [PTR_W-1:0] ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             uf_q;

  // Next-state values and RAS write port.
  logic [XLEN-1:0]  pc_d;
  logic [PTR_W-1:0] ptr_d;
  logic [CNT_W-1:0] cnt_d;
  logic             uf_d;
  logic             wr_en;
  logic [PTR_W-1:0] wr_idx;

  // Helpers derived from the registered state only.
  logic [XLEN-1:0]  pc_plus4;
  logic [XLEN-1:0]  link_addr;
  logic [XLEN-1:0]  top_entry;
  logic             ras_has_entry;
  logic             pop;

  assign pc_plus4      = pc_q + XLEN'(4);
  assign link_addr     = pc_q + XLEN'(LINK_OFFSET);
  assign top_entry     = ras_q[ptr_q];
  assign ras_has_entry = (cnt_q != '0);

  // Next-PC selection and RAS bookkeeping for the coming edge.
  // NOTE: every signal written here gets a default before any branch, so no
  // path through the if/case leaves one unassigned and no latch is inferred.
  always_comb begin
    pc_d   = pc_q;
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    uf_d   = 1'b0;
    wr_en  = 1'b0;
    wr_idx = ptr_q;
    pop    = 1'b0;

    if (bus.req) begin
      // Exception entry wins over everything else; the RAS is left alone.
      pc_d = EXC_VEC;
    end else if (bus.stall) begin
      // Hazard hold: pc and RAS keep their values, underflow drops to 0.
      pc_d = pc_q;
    end else begin
      case (bus.pc_op)
        OP_NORMAL: pc_d = pc_plus4;
        OP_BRANCH: pc_d = pc_plus4 + bus.br_off;
        OP_JUMP:   pc_d = bus.j_target;
        OP_JR:     pc_d = bus.jr_target;
        OP_ERET:   pc_d = bus.epc;
        OP_RET: begin
          if (ras_has_entry) begin
            pc_d = top_entry;
            pop  = 1'b1;
          end else begin
            // Mispredicted return: fall through and flag it for one cycle.
            pc_d = pc_plus4;
            uf_d = 1'b1;
          end
        end
        default:   pc_d = pc_q;
      endcase

      if (bus.call && pop) begin
        // Pop and push together: the link replaces the slot just consumed,
        // so neither pointer nor count moves.
        wr_en  = 1'b1;
        wr_idx = ptr_q;
      end else if (bus.call) begin
        // Plain push; when full the advance lands on the oldest entry.
        wr_en  = 1'b1;
        wr_idx = ptr_q + PTR_W'(1);
        ptr_d  = ptr_q + PTR_W'(1);
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else if (pop) begin
        // Entries are not cleared on pop; the count alone marks validity.
        ptr_d = ptr_q - PTR_W'(1);
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  // PC, RAS control and underflow registers.
  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q  <= RESET_VEC;
      ptr_q <= '0;
      cnt_q <= '0;
      uf_q  <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      uf_q  <= uf_d;
    end
  end

  // RAS storage write port.
  // NOTE: the stack is small, so its entries are reset along with the rest
  // of the state; nothing stale can ever appear on ras_top after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RAS_DEPTH; i++) begin
        ras_q[i] <= '0;
      end
    end else if (wr_en) begin
      ras_q[wr_idx] <= link_addr;
    end
  end

  // Status outputs come straight from registered state.
  assign bus.pc            = pc_q;
  assign bus.ras_top       = ras_has_entry ? top_entry : '0;
  assign bus.ras_empty     = ~ras_has_entry;
  assign bus.ras_full      = (cnt_q == CNT_MAX);
  assign bus.ras_underflow = uf_q;
  assign bus.pc_misaligned = (pc_q[1:0] != 2'b00);

endmodule : pc_gen
